// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared encodings and cause constants for the execute-stage trap/redirect control
package ctrl_pkg;

    typedef enum logic [1:0] {
        BR_NONE  = 2'b00,
        BR_TAKEN = 2'b01,
        BR_TRAP  = 2'b10
    } br_code_e;

    typedef enum logic [1:0] {
        SYS_NONE  = 2'b00,
        SYS_ECALL = 2'b01,
        SYS_MRET  = 2'b10
    } sys_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_SAVE = 2'b01,
        ST_JUMP = 2'b10
    } trap_state_e;

    localparam int unsigned CAUSE_IRQ_UART = 11;
    localparam int unsigned CAUSE_ECALL_M  = 11;
    localparam logic [6:0]  OPC_SYSTEM     = 7'b1110011;

endpackage

// File: rtl/trap_redirect_ctrl_if.sv
// rtl/trap_redirect_ctrl_if.sv - execute-stage control bundle between pipeline/CSR file and trap_redirect_ctrl
interface trap_redirect_ctrl_if #(
    parameter int XLEN = 32
);
    logic [1:0]      br_taken;
    logic [XLEN-1:0] br_target;
    logic [XLEN-1:0] pc_E;
    logic            valid_E;
    logic [1:0]      sys_op_E;
    logic            irq_req;
    logic            mie;
    logic [XLEN-1:0] mtvec;
    logic [XLEN-1:0] mepc;
    logic            stall_in;

    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            flush_D;
    logic            flush_E;
    logic            stall_F;
    logic            mepc_we;
    logic [XLEN-1:0] mepc_wdata;
    logic            mcause_we;
    logic [XLEN-1:0] mcause_wdata;
    logic            mie_clear;
    logic            mie_restore;
    logic            irq_ack;

    modport master (
        output br_taken, br_target, pc_E, valid_E, sys_op_E, irq_req,
               mie, mtvec, mepc, stall_in,
        input  redirect_valid, redirect_pc, flush_D, flush_E, stall_F,
               mepc_we, mepc_wdata, mcause_we, mcause_wdata,
               mie_clear, mie_restore, irq_ack
    );

    modport slave (
        input  br_taken, br_target, pc_E, valid_E, sys_op_E, irq_req,
               mie, mtvec, mepc, stall_in,
        output redirect_valid, redirect_pc, flush_D, flush_E, stall_F,
               mepc_we, mepc_wdata, mcause_we, mcause_wdata,
               mie_clear, mie_restore, irq_ack
    );
endinterface

// File: rtl/trap_vec_calc.sv
// rtl/trap_vec_calc.sv - trap target from mtvec and cause; VECTORED_IRQ_EN enables vectored interrupt entry
module trap_vec_calc
    import ctrl_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int IRQ_CODE = CAUSE_IRQ_UART
) (
    input  logic [XLEN-1:0] i_mtvec,
    input  logic            i_is_irq,
    output logic [XLEN-1:0] o_target
);
    logic [XLEN-1:0] w_base;

    assign w_base = {i_mtvec[XLEN-1:2], 2'b00};

`ifdef VECTORED_IRQ_EN
    // Mode 01 is vectored, but only interrupts use the per-cause slot.
    always_comb begin
        o_target = w_base;
        if ((i_mtvec[1:0] == 2'b01) && i_is_irq)
            o_target = w_base + XLEN'(4 * IRQ_CODE);
    end
`else
    logic w_unused;
    assign w_unused = &{1'b0, i_mtvec[1:0], i_is_irq};
    assign o_target = w_base;
`endif

endmodule

// File: rtl/trap_redirect_ctrl.sv
// rtl/trap_redirect_ctrl.sv - arbitrates irq/ecall/mret/branch into redirect, flush/stall and CSR strobes (option: VECTORED_IRQ_EN)
module trap_redirect_ctrl
    import ctrl_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int IRQ_CODE   = CAUSE_IRQ_UART,
    parameter int ECALL_CODE = CAUSE_ECALL_M
) (
    input logic                clk,
    input logic                rst_n,
    trap_redirect_ctrl_if.slave bus
);
    trap_state_e     r_state;
    logic            r_irq_pending;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_cause;

    logic            w_go, w_take_irq, w_take_ecall, w_take_mret, w_take_branch, w_trap;
    logic [XLEN-1:0] w_cause, w_vec_target;
    logic            w_redirect_valid, w_flush_d, w_flush_e, w_stall_f;
    logic            w_mepc_we, w_mcause_we, w_mie_clear, w_mie_restore, w_irq_ack;
    logic [XLEN-1:0] w_redirect_pc, w_mepc_wdata, w_mcause_wdata;

    assign w_go          = (r_state == ST_IDLE) && !bus.stall_in && bus.valid_E;
    assign w_take_irq    = w_go && r_irq_pending && bus.mie;
    assign w_take_ecall  = w_go && !w_take_irq &&
                           ((bus.sys_op_E == SYS_ECALL) || (bus.br_taken == BR_TRAP));
    assign w_take_mret   = w_go && !w_take_irq && !w_take_ecall && (bus.sys_op_E == SYS_MRET);
    assign w_take_branch = w_go && !w_take_irq && !w_take_ecall && !w_take_mret &&
                           (bus.br_taken == BR_TAKEN);
    assign w_trap        = w_take_irq || w_take_ecall;
    assign w_cause       = w_take_irq ? {1'b1, (XLEN-1)'(IRQ_CODE)} : {1'b0, (XLEN-1)'(ECALL_CODE)};

    trap_vec_calc #(.XLEN(XLEN), .IRQ_CODE(IRQ_CODE)) u_vec (
        .i_mtvec  (bus.mtvec),
        .i_is_irq (r_cause[XLEN-1]),
        .o_target (w_vec_target)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_irq_pending <= 1'b0;
            r_pc          <= '0;
            r_cause       <= '0;
        end else begin
            r_irq_pending <= bus.irq_req | (r_irq_pending & ~w_irq_ack);
            case (r_state)
                ST_IDLE: if (w_trap) begin
                    r_state <= ST_SAVE;
                    r_pc    <= bus.pc_E;
                    r_cause <= w_cause;
                end
                ST_SAVE: r_state <= ST_JUMP;
                ST_JUMP: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Outputs are forced low while reset is asserted so a mid-sequence reset drops them at once.
    always_comb begin
        w_redirect_valid = 1'b0;
        w_redirect_pc    = '0;
        w_flush_d        = 1'b0;
        w_flush_e        = 1'b0;
        w_stall_f        = 1'b0;
        w_mepc_we        = 1'b0;
        w_mepc_wdata     = '0;
        w_mcause_we      = 1'b0;
        w_mcause_wdata   = '0;
        w_mie_clear      = 1'b0;
        w_mie_restore    = 1'b0;
        w_irq_ack        = 1'b0;
        if (rst_n) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_trap) begin
                        w_flush_d = 1'b1;
                        w_flush_e = 1'b1;
                        w_stall_f = 1'b1;
                    end else if (w_take_mret) begin
                        w_redirect_valid = 1'b1;
                        w_redirect_pc    = bus.mepc;
                        w_flush_d        = 1'b1;
                        w_mie_restore    = 1'b1;
                    end else if (w_take_branch) begin
                        w_redirect_valid = 1'b1;
                        w_redirect_pc    = bus.br_target;
                        w_flush_d        = 1'b1;
                    end
                end
                ST_SAVE: begin
                    w_mepc_we      = 1'b1;
                    w_mepc_wdata   = r_pc;
                    w_mcause_we    = 1'b1;
                    w_mcause_wdata = r_cause;
                    w_mie_clear    = 1'b1;
                    w_stall_f      = 1'b1;
                    w_flush_d      = 1'b1;
                end
                ST_JUMP: begin
                    w_redirect_valid = 1'b1;
                    w_redirect_pc    = w_vec_target;
                    w_flush_d        = 1'b1;
                    w_irq_ack        = r_cause[XLEN-1];
                end
                default: ;
            endcase
        end
    end

    assign bus.redirect_valid = w_redirect_valid;
    assign bus.redirect_pc    = w_redirect_pc;
    assign bus.flush_D        = w_flush_d;
    assign bus.flush_E        = w_flush_e;
    assign bus.stall_F        = w_stall_f;
    assign bus.mepc_we        = w_mepc_we;
    assign bus.mepc_wdata     = w_mepc_wdata;
    assign bus.mcause_we      = w_mcause_we;
    assign bus.mcause_wdata   = w_mcause_wdata;
    assign bus.mie_clear      = w_mie_clear;
    assign bus.mie_restore    = w_mie_restore;
    assign bus.irq_ack        = w_irq_ack;

endmodule
